// File: rtl/dmem_responder.sv
// Word-organised data memory behind the MIPS MEM-stage bus.
// Clears itself after reset; host port runs in the gaps left by CPU traffic.
module dmem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dmemread,
  input  logic                      dmemwrite,
  input  logic [DATA_BUS_WIDTH-1:0] dadr,
  input  logic [DATA_WIDTH-1:0]     dmemwd,
  output logic [DATA_WIDTH-1:0]     dmemrd,
  input  logic                      host_valid,
  input  logic                      host_we,
  input  logic [ADDR_WIDTH-1:0]     host_adr,
  input  logic [DATA_WIDTH-1:0]     host_wd,
  output logic                      host_ready,
  output logic [DATA_WIDTH-1:0]     host_rd,
  output logic                      host_rvalid,
  output logic                      busy,
  output logic                      err,
  output logic [DATA_BUS_WIDTH-1:0] err_adr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    legal;
  logic                    idle;
  logic                    run;
  logic                    clr_we;
  logic                    cpu_acc;
  logic                    cpu_we;
  logic                    bad;
  logic                    host_acc;

  // Out-of-range high bits must be zero: no aliasing onto the array.
  assign idx   = dadr[ADDR_WIDTH+1:2];
  assign legal = (dadr[1:0] == 2'b00) &&
                 (dadr[DATA_BUS_WIDTH-1:ADDR_WIDTH+2] == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    idle    = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q)
          state_d = S_IDLE;
      end
      S_IDLE: idle = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign run        = reset & idle;
  assign busy       = ~run;
  assign cpu_acc    = dmemread | dmemwrite;
  assign cpu_we     = run & dmemwrite & legal;
  assign bad        = run & cpu_acc & ~legal;
  assign host_ready = run & ~cpu_acc;
  assign host_acc   = host_valid & host_ready;
  assign dmemrd     = (run & dmemread & legal) ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (CLEAR_ON_RESET)
        state_q <= S_CLEAR;
      else
        state_q <= S_IDLE;
      cnt_q       <= '0;
      host_rd     <= '0;
      host_rvalid <= 1'b0;
      err         <= 1'b0;
      err_adr     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      host_rvalid <= host_acc & ~host_we;
      if (host_acc & ~host_we)
        host_rd <= mem[host_adr];
      if (bad) begin
        err <= 1'b1;
        if (!err)
          err_adr <= dadr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (clr_we)
        mem[cnt_q] <= '0;
      else if (cpu_we)
        mem[idx] <= dmemwd;
      else if (host_acc & host_we)
        mem[host_adr] <= host_wd;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: queued expectations from a
// flat array model, popped by a negedge monitor.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmemread = 1'b0;
  logic        dmemwrite = 1'b0;
  logic [31:0] dadr = '0;
  logic [31:0] dmemwd = '0;
  logic [31:0] dmemrd;
  logic        host_valid = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_adr = '0;
  logic [31:0] host_wd = '0;
  logic        host_ready;
  logic [31:0] host_rd;
  logic        host_rvalid;
  logic        busy;
  logic        err;
  logic [31:0] err_adr;

  dmem_responder dut (
    .clk(clk), .reset(reset),
    .dmemread(dmemread), .dmemwrite(dmemwrite),
    .dadr(dadr), .dmemwd(dmemwd), .dmemrd(dmemrd),
    .host_valid(host_valid), .host_we(host_we),
    .host_adr(host_adr), .host_wd(host_wd),
    .host_ready(host_ready), .host_rd(host_rd),
    .host_rvalid(host_rvalid), .busy(busy),
    .err(err), .err_adr(err_adr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          clr_left = 0;
  logic [31:0] model [256];
  bit          err_m = 0;
  logic [31:0] erradr_m = '0;
  logic [31:0] cq [$];
  logic [31:0] hq [$];
  int          ht [$];
  bit          a;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (host_rvalid) begin
        if (hq.size() == 0) begin
          chk("host_rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          chk("host_rd", host_rd, hq.pop_front());
          chk("host_rvalid_latency", cyc, ht.pop_front());
        end
      end else if (ht.size() != 0 && ht[0] < cyc) begin
        chk("host_rvalid_missing", 32'd0, 32'd1);
        void'(hq.pop_front());
        void'(ht.pop_front());
      end
      if (dmemread) begin
        if (cq.size() == 0)
          chk("cpu_read_unexpected", 32'd1, 32'd0);
        else
          chk("dmemrd", dmemrd, cq.pop_front());
      end else begin
        chk("dmemrd_idle_zero", dmemrd, 32'd0);
      end
    end
  end

  task automatic step(input bit rd, input bit wr,
                      input logic [31:0] adr, input logic [31:0] wd,
                      input bit hv, input bit hwe,
                      input logic [7:0] ha, input logic [31:0] hw,
                      output bit acc);
    bit         idle_m, lg, rdy;
    logic [7:0] ix;
    idle_m = (clr_left == 0);
    lg     = (adr[1:0] == 2'b00) && (adr < 32'h400);
    ix     = adr[9:2];
    rdy    = idle_m && !rd && !wr;
    acc    = hv && rdy;
    dmemread = rd; dmemwrite = wr; dadr = adr; dmemwd = wd;
    host_valid = hv; host_we = hwe; host_adr = ha; host_wd = hw;
    if (rd)
      cq.push_back((idle_m && lg) ? model[ix] : 32'd0);
    if (acc && !hwe) begin
      hq.push_back(model[ha]);
      ht.push_back(cyc + 1);
    end
    @(negedge clk);
    chk("busy", {31'd0, busy}, {31'd0, !idle_m});
    chk("host_ready", {31'd0, host_ready}, {31'd0, rdy});
    chk("err", {31'd0, err}, {31'd0, err_m});
    chk("err_adr", err_adr, erradr_m);
    @(posedge clk);
    if (!idle_m) begin
      clr_left--;
    end else begin
      if ((rd || wr) && !lg) begin
        if (!err_m) erradr_m = adr;
        err_m = 1'b1;
      end
      if (wr && lg) model[ix] = wd;
      if (acc && hwe) model[ha] = hw;
    end
    #1;
  endtask

  task automatic nop();
    bit x;
    step(0, 0, 0, 0, 0, 0, 0, 0, x);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    dmemread = 1'b1; dmemwrite = 1'b0; dadr = 32'h10; dmemwd = '0;
    host_valid = 1'b1; host_we = 1'b0; host_adr = '0; host_wd = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_host_ready", {31'd0, host_ready}, 32'd0);
    chk("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_host_rd", host_rd, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_adr", err_adr, 32'd0);
    chk("rst_dmemrd", dmemrd, 32'd0);
    dmemread = 1'b0; host_valid = 1'b0;
    reset = 1'b1;
    clr_left = 256;
    err_m = 1'b0;
    erradr_m = '0;
    foreach (model[i]) model[i] = '0;
    cq.delete(); hq.delete(); ht.delete();
  endtask

  function automatic logic [31:0] radr();
    int unsigned r, w;
    r = $urandom % 20;
    w = $urandom_range(0, 31);
    if (r == 0) return $urandom;
    if (r == 1) return (32'(w) << 2) | 32'd2;
    if (r == 2) return 32'h3FC;
    return 32'(w) << 2;
  endfunction

  initial begin
    bit          pv, pwe;
    logic [7:0]  pa;
    logic [31:0] pw;
    #1;
    do_reset(2);
    for (int i = 0; i < 256; i++) begin
      if (i == 50)      step(0, 1, 32'h40, 32'hFFFF, 0, 0, 0, 0, a);
      else if (i == 60) step(1, 1, 32'h13, 32'h1, 1, 0, 0, 0, a);
      else              nop();
    end
    step(0, 0, 0, 0, 1, 0, 8'h3F, 0, a);
    step(0, 0, 0, 0, 1, 0, 8'h10, 0, a);
    nop();

    step(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, a);
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 0, 8'h04, 0, a);
    nop();

    step(0, 1, 32'h12, 32'h12345678, 0, 0, 0, 0, a);
    step(1, 0, 32'h400, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 0, 8'h04, 0, a);
    nop();

    for (int i = 0; i < 3; i++)
      step(1, 0, 32'h10, 0, 1, 1, 8'h07, 32'h55, a);
    step(0, 0, 0, 0, 1, 1, 8'h07, 32'h55, a);
    chk("host_accept_4th", {31'd0, a}, 32'd1);
    step(0, 0, 0, 0, 1, 0, 8'h07, 0, a);
    step(1, 0, 32'h1C, 0, 0, 0, 0, 0, a);

    step(0, 1, 32'h20, 32'h1, 0, 0, 0, 0, a);
    step(1, 1, 32'h20, 32'h2, 0, 0, 0, 0, a);
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, a);
    step(0, 1, 32'hFFC, 32'h9, 0, 0, 0, 0, a);
    step(0, 1, 32'h3FC, 32'hA, 0, 0, 0, 0, a);
    step(0, 1, 32'h3FC, 32'hB, 0, 0, 0, 0, a);
    step(1, 0, 32'h3FC, 0, 0, 0, 0, 0, a);

    pv = 0; pwe = 0; pa = '0; pw = '0;
    for (int i = 0; i < 1500; i++) begin
      int unsigned k;
      if (!pv && ($urandom % 3 == 0)) begin
        pv  = 1;
        pwe = $urandom_range(0, 1);
        pa  = 8'($urandom_range(0, 31));
        if ($urandom % 8 == 0) pa = 8'hFF;
        pw  = $urandom;
      end
      k = $urandom % 4;
      step(k == 1 || k == 3, k == 2 || k == 3, radr(), $urandom,
           pv, pwe, pa, pw, a);
      if (a) pv = 0;
    end
    nop();
    nop();

    do_reset(2);
    for (int i = 0; i < 100; i++) nop();
    do_reset(1);
    for (int i = 0; i < 256; i++) nop();
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 0, 8'h07, 0, a);
    nop();
    nop();

    chk("cpu_queue_drained", cq.size(), 0);
    chk("host_queue_drained", hq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
